scs8hd_pwrgate_ctl: RTL



---
 rtl/scs8hd_pwrgate_pkg.sv | 60 ++++++
 rtl/scs8hd_pwrgate_ctl_if.sv | 54 +++++
 rtl/scs8hd_pwrgate_cnt.sv | 41 ++++
 rtl/scs8hd_pwrgate_ctl_chk.sv | 23 ++
 rtl/scs8hd_pwrgate_ctl.sv | 140 ++++++++++++++
 5 files changed

// File: rtl/scs8hd_pwrgate_pkg.sv
// Shared types and constants for the scs8hd power-gating sequencer:
// state encoding, per-state output vectors and default cycle counts.
package scs8hd_pwrgate_pkg;

    typedef enum logic [2:0] {
        ST_OFF  = 3'd0,
        ST_PUP  = 3'd1,
        ST_RREL = 3'd2,
        ST_ON   = 3'd3,
        ST_ISOA = 3'd4,
        ST_PDN  = 3'd5
    } pg_state_e;

    typedef struct packed {
        logic psw_en;
        logic iso;
        logic drstb;
        logic ready;
        logic busy;
    } pg_out_t;

    localparam pg_out_t OUT_OFF  = '{psw_en: 1'b0, iso: 1'b1, drstb: 1'b0, ready: 1'b0, busy: 1'b0};
    localparam pg_out_t OUT_PUP  = '{psw_en: 1'b1, iso: 1'b1, drstb: 1'b0, ready: 1'b0, busy: 1'b1};
    localparam pg_out_t OUT_RREL = '{psw_en: 1'b1, iso: 1'b1, drstb: 1'b1, ready: 1'b0, busy: 1'b1};
    localparam pg_out_t OUT_ON   = '{psw_en: 1'b1, iso: 1'b0, drstb: 1'b1, ready: 1'b1, busy: 1'b0};
    localparam pg_out_t OUT_ISOA = '{psw_en: 1'b1, iso: 1'b1, drstb: 1'b1, ready: 1'b0, busy: 1'b1};
    localparam pg_out_t OUT_PDN  = '{psw_en: 1'b0, iso: 1'b1, drstb: 1'b0, ready: 1'b0, busy: 1'b1};

    localparam int unsigned ISO_CYC_DEF = 32'd2;
    localparam int unsigned PSW_CYC_DEF = 32'd8;
    localparam int unsigned RST_CYC_DEF = 32'd4;
    localparam int unsigned CNT_W_DEF   = 32'd8;

    // Output vector for a state; any unknown encoding falls back to the safe OFF vector.
    function automatic pg_out_t state_out(input pg_state_e st);
        pg_out_t o;
        case (st)
            ST_OFF:  o = OUT_OFF;
            ST_PUP:  o = OUT_PUP;
            ST_RREL: o = OUT_RREL;
            ST_ON:   o = OUT_ON;
            ST_ISOA: o = OUT_ISOA;
            ST_PDN:  o = OUT_PDN;
            default: o = OUT_OFF;
        endcase
        return o;
    endfunction

    // Counter load value for an N-cycle state; a zero count behaves as one cycle.
    function automatic int unsigned cyc_load(input int unsigned cyc);
        int unsigned v;
        if (cyc == 32'd0) begin
            v = 32'd0;
        end else begin
            v = cyc - 32'd1;
        end
        return v;
    endfunction

endpackage

// File: rtl/scs8hd_pwrgate_ctl_if.sv
// Request/control bundle between the always-on sequencer and the gated domain.
// PWRGOOD exists only when SC_PWRGOOD_EN is defined.
interface scs8hd_pwrgate_ctl_if;

    logic SLEEP;
    logic PSW_EN;
    logic ISO;
    logic DRSTB;
    logic READY;
    logic BUSY;

`ifdef SC_PWRGOOD_EN
    logic PWRGOOD;

    modport master (
        input  SLEEP,
        input  PWRGOOD,
        output PSW_EN,
        output ISO,
        output DRSTB,
        output READY,
        output BUSY
    );

    modport slave (
        output SLEEP,
        output PWRGOOD,
        input  PSW_EN,
        input  ISO,
        input  DRSTB,
        input  READY,
        input  BUSY
    );
`else
    modport master (
        input  SLEEP,
        output PSW_EN,
        output ISO,
        output DRSTB,
        output READY,
        output BUSY
    );

    modport slave (
        output SLEEP,
        input  PSW_EN,
        input  ISO,
        input  DRSTB,
        input  READY,
        input  BUSY
    );
`endif

endinterface

// File: rtl/scs8hd_pwrgate_cnt.sv
// Loadable down-counter that parks at zero; zero flag is registered with the count.
module scs8hd_pwrgate_cnt #(
    parameter int unsigned CNT_W = 32'd8
) (
    input  logic             clk,
    input  logic             resetb,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             zero_r;

    // Next count: load wins, otherwise count down until zero and hold there.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (load) begin
            cnt_nxt_s = load_val;
        end else if (!zero_r) begin
            cnt_nxt_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Count and zero-flag registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (!resetb) begin
            cnt_r  <= {CNT_W{1'b0}};
            zero_r <= 1'b1;
        end else begin
            cnt_r  <= cnt_nxt_s;
            zero_r <= (cnt_nxt_s == {CNT_W{1'b0}});
        end
    end

    assign zero = zero_r;

endmodule

// File: rtl/scs8hd_pwrgate_ctl_chk.sv
// Ordering checks on the sequencer outputs: isolation must cover any
// unpowered or reset state of the domain.
module scs8hd_pwrgate_ctl_chk (
    input logic clk,
    input logic resetb,
    input logic psw_en,
    input logic iso,
    input logic drstb
);

    // Clamps are on whenever the rail is off or the domain is held in reset.
    a_iso_cover: assert property (@(posedge clk) disable iff (!resetb)
        (!psw_en || !drstb) |-> iso);

    // Isolation is already up by the cycle the switch opens.
    a_iso_before_off: assert property (@(posedge clk) disable iff (!resetb)
        $fell(psw_en) |-> iso);

    // Reset is never released while the rail is disconnected.
    a_rst_needs_pwr: assert property (@(posedge clk) disable iff (!resetb)
        drstb |-> psw_en);

endmodule

// File: rtl/scs8hd_pwrgate_ctl.sv
// Power-gating sequencer: orders header switch, isolation clamps and domain
// reset. Optional rail acknowledge via SC_PWRGOOD_EN.
module scs8hd_pwrgate_ctl
    import scs8hd_pwrgate_pkg::*;
#(
    parameter int unsigned ISO_CYC = ISO_CYC_DEF,
    parameter int unsigned PSW_CYC = PSW_CYC_DEF,
    parameter int unsigned RST_CYC = RST_CYC_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF
) (
    input logic                  CLK,
    input logic                  RESETB,
    scs8hd_pwrgate_ctl_if.master pg
);

    localparam logic [CNT_W-1:0] ISO_LD = CNT_W'(cyc_load(ISO_CYC));
    localparam logic [CNT_W-1:0] PSW_LD = CNT_W'(cyc_load(PSW_CYC));
    localparam logic [CNT_W-1:0] RST_LD = CNT_W'(cyc_load(RST_CYC));

    pg_state_e        state_r;
    pg_state_e        next_s;
    pg_out_t          out_r;
    logic             load_s;
    logic [CNT_W-1:0] load_val_s;
    logic             zero_s;
    logic             up_ok_s;
    logic             dn_ok_s;

`ifdef SC_PWRGOOD_EN
    logic pg_meta_r;
    logic pg_sync_r;

    // Two-flop synchroniser for the switch's rail-good acknowledge.
    always_ff @(posedge CLK) begin
        if (!RESETB) begin
            pg_meta_r <= 1'b0;
            pg_sync_r <= 1'b0;
        end else begin
            pg_meta_r <= pg.PWRGOOD;
            pg_sync_r <= pg_meta_r;
        end
    end

    assign up_ok_s = pg_sync_r;
    assign dn_ok_s = !pg_sync_r;
`else
    assign up_ok_s = 1'b1;
    assign dn_ok_s = 1'b1;
`endif

    scs8hd_pwrgate_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk      (CLK),
        .resetb   (RESETB),
        .load     (load_s),
        .load_val (load_val_s),
        .zero     (zero_s)
    );

    // Next state and counter load; SLEEP is only looked at in the two stable states.
    always_comb begin
        next_s     = state_r;
        load_s     = 1'b0;
        load_val_s = {CNT_W{1'b0}};
        case (state_r)
            ST_OFF: begin
                if (!pg.SLEEP) begin
                    next_s     = ST_PUP;
                    load_s     = 1'b1;
                    load_val_s = PSW_LD;
                end else begin
                    next_s = ST_OFF;
                end
            end
            ST_PUP: begin
                if (zero_s && up_ok_s) begin
                    next_s     = ST_RREL;
                    load_s     = 1'b1;
                    load_val_s = RST_LD;
                end else begin
                    next_s = ST_PUP;
                end
            end
            ST_RREL: begin
                if (zero_s) begin
                    next_s = ST_ON;
                end else begin
                    next_s = ST_RREL;
                end
            end
            ST_ON: begin
                if (pg.SLEEP) begin
                    next_s     = ST_ISOA;
                    load_s     = 1'b1;
                    load_val_s = ISO_LD;
                end else begin
                    next_s = ST_ON;
                end
            end
            ST_ISOA: begin
                if (zero_s) begin
                    next_s     = ST_PDN;
                    load_s     = 1'b1;
                    load_val_s = PSW_LD;
                end else begin
                    next_s = ST_ISOA;
                end
            end
            ST_PDN: begin
                if (zero_s && dn_ok_s) begin
                    next_s = ST_OFF;
                end else begin
                    next_s = ST_PDN;
                end
            end
            default: begin
                next_s = ST_OFF;
            end
        endcase
    end

    // State register plus outputs registered from the next-state decode.
    always_ff @(posedge CLK) begin
        if (!RESETB) begin
            state_r <= ST_OFF;
            out_r   <= OUT_OFF;
        end else begin
            state_r <= next_s;
            out_r   <= state_out(next_s);
        end
    end

    assign pg.PSW_EN = out_r.psw_en;
    assign pg.ISO    = out_r.iso;
    assign pg.DRSTB  = out_r.drstb;
    assign pg.READY  = out_r.ready;
    assign pg.BUSY   = out_r.busy;

endmodule
